// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB down-counting timer with prescaler, auto-reload and level interrupt
// Five word registers; PREADY is combinational from the wait counter, so WAIT_STATES=0 gives zero-wait access.
module apb_timer #(
  parameter int WAIT_STATES = 1,
  parameter int PRESCALE_W  = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

  localparam logic [2:0] WAIT_LIM = 3'(WAIT_STATES);

  logic [2:0]            wait_cnt;
  logic                  ctrl_en, ctrl_auto, ctrl_ie;
  logic [31:0]           load_q, value_q;
  logic                  exp_q;
  logic [PRESCALE_W-1:0] prescale_q, presc_cnt;

  logic        access, mapped, wr_en, tick, expire;
  logic        sel_ctrl, sel_load, sel_value, sel_status, sel_presc;
  logic        wr_ctrl, wr_load, wr_status, wr_presc;
  logic [31:0] rdata_mux;
  logic        unused_addr;

  assign unused_addr = ^PADDR[31:5];

  assign access     = PSELx & PENABLE;
  assign sel_ctrl   = (PADDR[4:0] == 5'h00);
  assign sel_load   = (PADDR[4:0] == 5'h04);
  assign sel_value  = (PADDR[4:0] == 5'h08);
  assign sel_status = (PADDR[4:0] == 5'h0C);
  assign sel_presc  = (PADDR[4:0] == 5'h10);
  assign mapped     = sel_ctrl | sel_load | sel_value | sel_status | sel_presc;

  // Gated by reset so the handshake drops the instant PRESETn falls, even with zero wait states.
  assign PREADY  = PRESETn & access & (wait_cnt == WAIT_LIM);
  assign PSLVERR = PREADY & ~mapped;

  assign wr_en     = access & PWRITE & PREADY & mapped;
  assign wr_ctrl   = wr_en & sel_ctrl;
  assign wr_load   = wr_en & sel_load;
  assign wr_status = wr_en & sel_status;
  assign wr_presc  = wr_en & sel_presc;

  assign tick   = ctrl_en & (presc_cnt == prescale_q);
  assign expire = tick & (value_q == 32'd0);

  assign irq = exp_q & ctrl_ie;

  always_comb begin
    rdata_mux = '0;
    case (PADDR[4:0])
      5'h00:   rdata_mux = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
      5'h04:   rdata_mux = load_q;
      5'h08:   rdata_mux = value_q;
      5'h0C:   rdata_mux = {31'd0, exp_q};
      5'h10:   rdata_mux = 32'(prescale_q);
      default: rdata_mux = '0;
    endcase
  end

  assign PRDATA = (PREADY & ~PWRITE) ? rdata_mux : 32'd0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (!access || PREADY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_ie    <= 1'b0;
      load_q     <= '0;
      value_q    <= '0;
      exp_q      <= 1'b0;
      prescale_q <= '0;
      presc_cnt  <= '0;
    end else begin
      // Bus write to CTRL overrides the hardware EN clear at one-shot expiry.
      if (wr_ctrl) begin
        ctrl_en   <= PWDATA[0];
        ctrl_auto <= PWDATA[1];
        ctrl_ie   <= PWDATA[2];
      end else if (expire && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load)  load_q     <= PWDATA;
      if (wr_presc) prescale_q <= PWDATA[PRESCALE_W-1:0];

      if (expire) begin
        exp_q <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        exp_q <= 1'b0;
      end

      if (wr_load) begin
        value_q <= PWDATA;
      end else if (expire) begin
        if (ctrl_auto) value_q <= load_q;
      end else if (tick) begin
        value_q <= value_q - 32'd1;
      end

      // Restart the prescale period on LOAD writes and on any EN change via CTRL.
      if (!ctrl_en || tick || wr_load || (wr_ctrl && (!PWDATA[0] || !ctrl_en))) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter WAIT_STATES, default 1, SHALL set the number of PREADY-low cycles in each access phase (0..7).
REQ-002 Parameter PRESCALE_W, default 16, SHALL set the width of the PRESCALE register.
REQ-003 PCLK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 PRESETn, input, 1: reset, asynchronous, active-low.
REQ-005 PSELx, input, 1: slave select from the master bridge.
REQ-006 PENABLE, input, 1: APB access-phase strobe.
REQ-007 PWRITE, input, 1: 1 = write, 0 = read.
REQ-008 PADDR, input, 32: byte address; only PADDR[4:0] SHALL be decoded.
REQ-009 PWDATA, input, 32: write data.
REQ-010 PRDATA, output, 32: read data.
REQ-011 PREADY, output, 1: transfer-complete handshake.
REQ-012 PSLVERR, output, 1: error response for an unmapped offset.
REQ-013 irq, output, 1: timer interrupt, level-sensitive.

Function
REQ-014 Register map (word offsets):
- 0x00 CTRL RW: [0] EN, [1] AUTO, [2] IE.
- 0x04 LOAD RW: 32 bits.
- 0x08 VALUE RO: 32 bits.
- 0x0C STATUS: [0] EXP, write-1-to-clear.
- 0x10 PRESCALE RW: PRESCALE_W bits.
- Other offsets unmapped.
REQ-015 APB handshake:
- Setup phase = PSELx=1, PENABLE=0.
- Access phase = PSELx=1, PENABLE=1.
- In the access phase, PREADY SHALL be low for exactly WAIT_STATES cycles, then high for exactly one cycle.
- The wait counter SHALL clear whenever PSELx=0 or PENABLE=0.
REQ-016 A write SHALL commit on the edge where PSELx, PENABLE, PWRITE and PREADY are all 1; no other cycle SHALL modify registers through the bus.
REQ-017 PRDATA SHALL carry the addressed register (unused bits 0) while PREADY=1 in a read access phase, and SHALL be 0 in every other cycle.
REQ-018 PSLVERR SHALL equal 1 only in the PREADY=1 cycle of an access to an unmapped offset; such writes SHALL be ignored and such reads SHALL return 0.
REQ-019 Prescaler:
- While EN=1, the prescaler SHALL count 0..PRESCALE and wrap to 0.
- The wrap cycle is a "tick", so one tick occurs every PRESCALE+1 cycles.
- While EN=0, the prescaler SHALL be held at 0.
REQ-020 On a tick with VALUE!=0, VALUE SHALL decrement by 1.
REQ-021 On a tick with VALUE==0:
- EXP SHALL set.
- If AUTO=1, VALUE SHALL reload from LOAD and EN SHALL stay 1.
- If AUTO=0, EN SHALL clear and VALUE SHALL stay 0.
REQ-022 A write to LOAD SHALL also copy PWDATA into VALUE and clear the prescaler, regardless of EN.
REQ-023 Writing CTRL with EN 0->1 SHALL clear the prescaler; the first tick follows PRESCALE+1 cycles later.
REQ-024 Simultaneous events:
- Hardware EXP set and a STATUS write-1-to-clear in the same cycle: set SHALL win.
- Hardware EN clear (REQ-021) and a CTRL write in the same cycle: the bus write SHALL win.
- A LOAD write and a tick in the same cycle: the LOAD write SHALL win.
REQ-025 irq SHALL be EXP AND IE, registered-free: it SHALL change in the same cycle that EXP or IE changes.
REQ-026 VALUE decrement SHALL NOT wrap below 0.
REQ-027 PRESCALE writes SHALL use PWDATA[PRESCALE_W-1:0].

Reset
REQ-028 Assertion of PRESETn=0 SHALL immediately, without a clock, force:
- CTRL, LOAD, VALUE, STATUS, PRESCALE and the prescaler to 0;
- the wait counter to 0;
- PREADY, PSLVERR and irq to 0;
- PRDATA to 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no register update; after deassertion, the first access SHALL start a fresh wait count.
REQ-030 The counter SHALL not tick before the first rising edge after PRESETn deassertion.

Verification
REQ-031 WAIT_STATES=1; write 0x04 <- 0x10:
- PREADY SHALL be low 1 access cycle, then high 1 cycle.
- A subsequent read of 0x08 SHALL return 0x10 with PSLVERR=0.
REQ-032 PRESCALE=3, LOAD=2, CTRL=0x5 (EN, IE, no AUTO):
- VALUE SHALL decrement every 4 cycles: 2 -> 1 -> 0.
- On the next tick, EXP=1 and irq=1; EN reads 0 and VALUE stays 0.
REQ-033 Same setup with CTRL=0x7 (AUTO):
- At expiry VALUE SHALL reload to 2 and EN SHALL stay 1.
- Writing STATUS <- 0x1 SHALL drop irq in the cycle after commit.
REQ-034 A STATUS W1C commit in the exact cycle of expiry SHALL leave EXP=1.
REQ-035 Access to offset 0x14:
- PSLVERR=1 in the PREADY cycle.
- A read SHALL return 0.
- A write SHALL leave all registers unchanged.
REQ-036 Assert PRESETn=0 during the wait cycle of a CTRL write <- 0x1:
- All outputs SHALL be 0 immediately.
- CTRL SHALL read 0 after reset release.
